// File: rtl/fifo_tx_drain_pkg.sv
// Shared definitions for the FIFO-to-UART drain block.
//   state_t        : 2-bit FSM encoding (IDLE=0, LOAD=1, WAIT_BUSY=2, SENDING=3)
//   DEF_DATA_WIDTH : default FIFO word / TX byte width
package fifo_tx_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_SENDING   = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;

endpackage : fifo_tx_drain_pkg

// File: rtl/fifo_tx_drain.sv
// Read-side consumer of the async FIFO, in the FIFO read / UART TX clock domain.
// Pops one byte at a time, presents it to the UART TX with a one-cycle valid
// strobe, frames the transfer on the TX busy flag, flags a sticky timeout when
// the TX never acknowledges, and counts completed transfers.
//
// Ports:
//   CLK            in   read/TX domain clock, rising edge
//   RST            in   asynchronous active-low reset
//   i_EN           in   enable; gates new transfers only
//   i_FIFO_EMPTY   in   FIFO empty flag
//   i_FIFO_RD_DATA in   FIFO head word (valid while not empty)
//   o_FIFO_RD_INC  out  one-cycle pop strobe
//   i_TX_BUSY      in   UART TX busy flag
//   o_TX_DATA      out  byte to transmit, held until the next capture
//   o_TX_VALID     out  one-cycle valid strobe
//   o_TIMEOUT      out  sticky: TX never raised busy after a valid strobe
//   o_BYTE_CNT     out  completed transfers, wraps
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for enable, non-empty FIFO and idle TX
// LOAD       | valid + pop strobes high for exactly one cycle
// WAIT_BUSY  | waiting for TX to acknowledge by raising busy (timed)
// SENDING    | TX busy; transfer counted when busy falls
module fifo_tx_drain
    import fifo_tx_drain_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_EN,
    input  logic                  i_FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] i_FIFO_RD_DATA,
    output logic                  o_FIFO_RD_INC,
    input  logic                  i_TX_BUSY,
    output logic [DATA_WIDTH-1:0] o_TX_DATA,
    output logic                  o_TX_VALID,
    output logic                  o_TIMEOUT,
    output logic [CNT_WIDTH-1:0]  o_BYTE_CNT
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] to_cnt;
    logic            capture;
    logic            to_inc;
    logic            to_fire;
    logic            sent;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        to_inc     = 1'b0;
        to_fire    = 1'b0;
        sent       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_EN && !i_FIFO_EMPTY && !i_TX_BUSY) begin
                    capture    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_TX_BUSY) begin
                    state_next = ST_SENDING;
                end else if (to_cnt == TO_LAST) begin
                    // Byte is dropped: no retry, not counted.
                    to_fire    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    to_inc = 1'b1;
                end
            end
            ST_SENDING: begin
                if (!i_TX_BUSY) begin
                    sent       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= ST_IDLE;
            to_cnt        <= '0;
            o_TX_DATA     <= '0;
            o_TX_VALID    <= 1'b0;
            o_FIFO_RD_INC <= 1'b0;
            o_TIMEOUT     <= 1'b0;
            o_BYTE_CNT    <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                o_TX_DATA <= i_FIFO_RD_DATA;
            end
            // Strobes are registered off the LOAD entry so they are high
            // exactly during the LOAD cycle; LOAD is only entered on !empty.
            o_TX_VALID    <= capture;
            o_FIFO_RD_INC <= capture;
            if (state == ST_LOAD) begin
                to_cnt <= '0;
            end else if (to_inc) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (to_fire) begin
                o_TIMEOUT <= 1'b1;
            end
            if (sent) begin
                o_BYTE_CNT <= o_BYTE_CNT + CNT_WIDTH'(1);
            end
        end
    end

endmodule : fifo_tx_drain

// File: tb/tb_fifo_tx_drain.sv
// Directed bench for fifo_tx_drain: FIFO model as a small array with read and
// write pointers, UART TX model that raises busy the cycle after each valid
// strobe for a programmable length, plus an external busy override.
module tb_fifo_tx_drain;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       en = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_inc;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       timeout;
    logic [15:0] byte_cnt;

    always #5 CLK = ~CLK;

    fifo_tx_drain #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .i_EN           (en),
        .i_FIFO_EMPTY   (fifo_empty),
        .i_FIFO_RD_DATA (fifo_rd_data),
        .o_FIFO_RD_INC  (fifo_rd_inc),
        .i_TX_BUSY      (tx_busy),
        .o_TX_DATA      (tx_data),
        .o_TX_VALID     (tx_valid),
        .o_TIMEOUT      (timeout),
        .o_BYTE_CNT     (byte_cnt)
    );

    // FIFO model
    logic [7:0] mem [0:15];
    logic [4:0] wr_ptr = '0;
    logic [4:0] rd_ptr = '0;
    int         n_pops = 0;
    int         n_bad_pops = 0;
    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_rd_data = fifo_empty ? 8'h00 : mem[rd_ptr[3:0]];

    always @(posedge CLK) begin
        if (fifo_rd_inc) begin
            if (rd_ptr == wr_ptr) n_bad_pops <= n_bad_pops + 1;
            else begin
                rd_ptr <= rd_ptr + 5'd1;
                n_pops <= n_pops + 1;
            end
        end
    end

    // TX model
    logic       tx_resp = 1'b1;
    int         tx_len = 10;
    logic       ext_busy = 1'b0;
    int         model_cnt = 0;
    logic [7:0] log_data [0:31];
    int         n_valid = 0;
    assign tx_busy = ext_busy | (model_cnt != 0);

    always @(posedge CLK) begin
        if (model_cnt > 0) model_cnt <= model_cnt - 1;
        if (tx_valid) begin
            log_data[n_valid[4:0]] <= tx_data;
            n_valid <= n_valid + 1;
            if (tx_resp) model_cnt <= tx_len;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic wait_cnt(input logic [15:0] target, input string name);
        int k = 0;
        while (byte_cnt !== target && k < 200) begin
            @(negedge CLK);
            k++;
        end
        n_checks++;
        if (byte_cnt !== target) begin
            n_fail++;
            $display("FAIL %s: byte_cnt=%0d want %0d", name, byte_cnt, target);
        end
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (tx_valid !== 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        n_checks++;
        if (tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: no valid strobe within 100 cycles", name);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({fifo_rd_inc, tx_valid, timeout} !== 3'b000 || tx_data !== 8'h00 || byte_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: inc=%b valid=%b to=%b data=%h cnt=%0d want all 0",
                     fifo_rd_inc, tx_valid, timeout, tx_data, byte_cnt);
        end
        RST = 1'b1;
        en  = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single();
        tx_len = 10;
        push(8'hA5);
        @(negedge CLK);
        n_checks++;
        if (tx_valid !== 1'b1 || fifo_rd_inc !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_start: valid=%b inc=%b data=%h want 1 1 a5",
                     tx_valid, fifo_rd_inc, tx_data);
        end
        @(negedge CLK);
        n_checks++;
        if (tx_valid !== 1'b0 || fifo_rd_inc !== 1'b0 || tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_pulse: valid=%b inc=%b data=%h want 0 0 a5",
                     tx_valid, fifo_rd_inc, tx_data);
        end
        wait_cnt(16'd1, "single_cnt");
    endtask

    task automatic test_back_to_back();
        int v0 = n_valid;
        int p0 = n_pops;
        tx_len = 5;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_cnt(16'd4, "b2b_cnt");
        repeat (3) @(negedge CLK);
        n_checks++;
        if (n_valid - v0 !== 3 || n_pops - p0 !== 3) begin
            n_fail++;
            $display("FAIL b2b_pulses: valid=%0d pops=%0d want 3 3", n_valid - v0, n_pops - p0);
        end
        n_checks++;
        if (log_data[1] !== 8'h01 || log_data[2] !== 8'h02 || log_data[3] !== 8'h03) begin
            n_fail++;
            $display("FAIL b2b_order: got %h %h %h want 01 02 03",
                     log_data[1], log_data[2], log_data[3]);
        end
        n_checks++;
        if (fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_empty: empty=%b want 1", fifo_empty);
        end
    endtask

    task automatic test_timeout();
        tx_resp = 1'b0;
        push(8'h55);
        wait_valid("to_valid");
        repeat (16) @(negedge CLK);
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: timeout=%b want 0", timeout);
        end
        @(negedge CLK);
        n_checks++;
        if (timeout !== 1'b1 || byte_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL to_set: timeout=%b cnt=%0d want 1 4", timeout, byte_cnt);
        end
        tx_resp = 1'b1;
        tx_len  = 4;
        push(8'h66);
        wait_cnt(16'd5, "to_next_cnt");
        n_checks++;
        if (log_data[5] !== 8'h66 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_next: data=%h timeout=%b want 66 1", log_data[5], timeout);
        end
    endtask

    task automatic test_enable();
        int seen = 0;
        en = 1'b0;
        push(8'h77);
        repeat (20) begin
            @(negedge CLK);
            if (tx_valid || fifo_rd_inc) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL en_gate: strobes=%0d want 0", seen);
        end
        en = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin
            n_fail++;
            $display("FAIL en_start: valid=%b data=%h want 1 77", tx_valid, tx_data);
        end
        wait_cnt(16'd6, "en_cnt");
    endtask

    task automatic test_ext_busy();
        int seen = 0;
        ext_busy = 1'b1;
        push(8'h88);
        repeat (10) begin
            @(negedge CLK);
            if (tx_valid || fifo_rd_inc) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL busy_gate: strobes=%0d want 0", seen);
        end
        ext_busy = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h88) begin
            n_fail++;
            $display("FAIL busy_start: valid=%b data=%h want 1 88", tx_valid, tx_data);
        end
        wait_cnt(16'd7, "busy_cnt");
    endtask

    task automatic test_reset_mid();
        tx_len = 10;
        push(8'h99);
        push(8'hAA);
        wait_valid("rst_valid");
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        n_checks++;
        if ({fifo_rd_inc, tx_valid, timeout} !== 3'b000 || tx_data !== 8'h00 || byte_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_async: inc=%b valid=%b to=%b data=%h cnt=%0d want all 0",
                     fifo_rd_inc, tx_valid, timeout, tx_data, byte_cnt);
        end
        @(negedge CLK);
        RST = 1'b1;
        wait_cnt(16'd1, "rst_resume_cnt");
        n_checks++;
        if (log_data[(n_valid - 1) % 32] !== 8'hAA || fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_resume: data=%h empty=%b want aa 1",
                     log_data[(n_valid - 1) % 32], fifo_empty);
        end
        n_checks++;
        if (n_bad_pops !== 0) begin
            n_fail++;
            $display("FAIL pop_on_empty: count=%0d want 0", n_bad_pops);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_enable();
        test_ext_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_tx_drain
